// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encodings, type-field width, flit width rule
// and the traffic generator FSM states.
package noc_pkg;

    localparam int HEAD_TAIL = 2;

    typedef enum logic [1:0] {
        FLIT_TAIL      = 2'b00,
        FLIT_HEAD      = 2'b01,
        FLIT_BODY      = 2'b10,
        FLIT_HEAD_TAIL = 2'b11
    } flit_type_t;

    typedef enum logic [1:0] {
        ST_GAP,
        ST_HEAD,
        ST_BODY,
        ST_DONE
    } tg_state_t;

    function automatic int flit_total_width(input int data_width);
        return data_width + HEAD_TAIL;
    endfunction

endpackage

// File: rtl/noc_lfsr.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, stepped only when advance is high.
module noc_lfsr #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    output logic [OUT_W-1:0] value
);

    logic [15:0] r_lfsr;
    logic        w_feedback;

    // Right-shift form of the polynomial: taps 16,14,13,11 land on bits 0,2,3,5.
    assign w_feedback = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= SEED;
        end else if (advance) begin
            r_lfsr <= {w_feedback, r_lfsr[15:1]};
        end
    end

    assign value = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/noc_traffic_gen.sv
// Spidergon NoC traffic generator: injects PACKET_LEN-flit packets separated by
// INJECT_GAP idle cycles, with a destination chosen by one of four traffic patterns.
module noc_traffic_gen
    import noc_pkg::*;
#(
    parameter int          NUM_OF_NODES            = 8,
    parameter int          FLIT_DATA_WIDTH         = 16,
    parameter int          NUM_OF_VIRTUAL_CHANNELS = 2,
    parameter int          NODE_ID                 = 0,
    parameter int          PACKET_LEN              = 4,
    parameter int          INJECT_GAP              = 2,
    parameter int          NUM_PACKETS             = 16,
    parameter int          HOTSPOT_NODE            = 0,
    parameter logic [15:0] LFSR_SEED               = 16'hACE1,
    localparam int         VW = (NUM_OF_VIRTUAL_CHANNELS > 1) ? $clog2(NUM_OF_VIRTUAL_CHANNELS) : 1
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          enable,
    input  logic [1:0]                                    mode,
    output logic [flit_total_width(FLIT_DATA_WIDTH)-1:0]  flit_out,
    output logic                                          flit_valid,
    input  logic                                          flit_ready,
    output logic [VW-1:0]                                 vc_sel,
    output logic [15:0]                                   packets_sent,
    output logic                                          done
);

    localparam int NW  = $clog2(NUM_OF_NODES);
    localparam int FW  = FLIT_DATA_WIDTH;
    localparam int PAD = FW - 2 * NW;
    localparam int IW  = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
    localparam int GW  = (INJECT_GAP > 0) ? $clog2(INJECT_GAP + 1) : 1;

    localparam logic [IW-1:0] LAST_IDX   = IW'(PACKET_LEN - 1);
    localparam logic [GW-1:0] GAP_END    = GW'(INJECT_GAP);
    localparam logic [VW-1:0] LAST_VC    = VW'(NUM_OF_VIRTUAL_CHANNELS - 1);
    localparam logic [NW-1:0] SRC_ID     = NW'(NODE_ID);
    localparam logic [15:0]   PKT_TARGET = 16'(NUM_PACKETS);

    tg_state_t     r_state, w_state_nxt;
    logic [GW-1:0] r_gap_cnt, w_gap_nxt;
    logic [IW-1:0] r_idx, w_idx_nxt;
    logic [NW-1:0] r_dest, w_dest_nxt;
    logic [VW-1:0] r_vc, w_vc_nxt;
    logic [VW-1:0] r_vc_ctr, w_vc_ctr_nxt;
    logic [15:0]   r_pkts, w_pkts_nxt;

    logic          w_start;
    logic          w_complete;
    logic          w_fire;
    logic [NW-1:0] w_lfsr;
    logic [NW-1:0] w_dest_raw;
    logic [NW-1:0] w_dest_sel;
    flit_type_t    w_type;
    logic [FW-1:0] w_data;

    noc_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (NW)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (w_start),
        .value   (w_lfsr)
    );

    always_comb begin
        case (mode)
            2'd0:    w_dest_raw = NW'(HOTSPOT_NODE);
            2'd1:    w_dest_raw = w_lfsr;
            2'd2:    w_dest_raw = NW'((NODE_ID + 1) % NUM_OF_NODES);
            default: w_dest_raw = ~SRC_ID;
        endcase
        // A generator never targets itself; bump to the next node on the ring.
        w_dest_sel = (w_dest_raw == SRC_ID) ? NW'((int'(w_dest_raw) + 1) % NUM_OF_NODES)
                                            : w_dest_raw;
    end

    assign flit_valid = (r_state == ST_HEAD) || (r_state == ST_BODY);
    assign w_fire     = flit_valid && flit_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_gap_nxt    = r_gap_cnt;
        w_idx_nxt    = r_idx;
        w_dest_nxt   = r_dest;
        w_vc_nxt     = r_vc;
        w_vc_ctr_nxt = r_vc_ctr;
        w_pkts_nxt   = r_pkts;
        w_start      = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            ST_GAP: begin
                if (enable) begin
                    if (r_gap_cnt == GAP_END) begin
                        w_state_nxt  = ST_HEAD;
                        w_start      = 1'b1;
                        w_dest_nxt   = w_dest_sel;
                        w_idx_nxt    = '0;
                        w_vc_nxt     = r_vc_ctr;
                        w_vc_ctr_nxt = (r_vc_ctr == LAST_VC) ? '0 : r_vc_ctr + 1'b1;
                    end else begin
                        w_gap_nxt = r_gap_cnt + 1'b1;
                    end
                end
            end
            ST_HEAD: begin
                if (w_fire) begin
                    if (PACKET_LEN == 1) begin
                        w_complete = 1'b1;
                    end else begin
                        w_state_nxt = ST_BODY;
                        w_idx_nxt   = IW'(1);
                    end
                end
            end
            ST_BODY: begin
                if (w_fire) begin
                    if (r_idx == LAST_IDX) w_complete = 1'b1;
                    else                   w_idx_nxt  = r_idx + 1'b1;
                end
            end
            default: ;
        endcase
        if (w_complete) begin
            w_pkts_nxt  = r_pkts + 16'd1;
            w_gap_nxt   = '0;
            w_state_nxt = ((NUM_PACKETS != 0) && (w_pkts_nxt == PKT_TARGET)) ? ST_DONE : ST_GAP;
        end
    end

    always_comb begin
        w_type = FLIT_TAIL;
        w_data = '0;
        case (r_state)
            ST_HEAD: begin
                w_type = (PACKET_LEN == 1) ? FLIT_HEAD_TAIL : FLIT_HEAD;
                w_data = FW'({r_dest, SRC_ID}) << PAD;
            end
            ST_BODY: begin
                w_type = (r_idx == LAST_IDX) ? FLIT_TAIL : FLIT_BODY;
                w_data = FW'(r_idx);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_GAP;
            r_gap_cnt <= '0;
            r_idx     <= '0;
            r_dest    <= '0;
            r_vc      <= '0;
            r_vc_ctr  <= '0;
            r_pkts    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_idx     <= w_idx_nxt;
            r_dest    <= w_dest_nxt;
            r_vc      <= w_vc_nxt;
            r_vc_ctr  <= w_vc_ctr_nxt;
            r_pkts    <= w_pkts_nxt;
        end
    end

    assign flit_out     = {w_type, w_data};
    assign vc_sel       = r_vc;
    assign packets_sent = r_pkts;
    assign done         = (r_state == ST_DONE);

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Directed bench for noc_traffic_gen: three generator instances with different
// node ids, packet lengths and patterns, each checked against hand-computed flits.
module tb_noc_traffic_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: N=8, NODE_ID=3, PACKET_LEN=4, INJECT_GAP=2, NUM_PACKETS=3
    logic        a_reset = 1'b1, a_en = 1'b0, a_ready = 1'b1;
    logic [1:0]  a_mode = 2'd2;
    logic [17:0] a_flit;
    logic        a_valid, a_done;
    logic [0:0]  a_vc;
    logic [15:0] a_pkts;

    // Instance B: NODE_ID=0, hotspot 0, PACKET_LEN=2, INJECT_GAP=1, unlimited
    logic        b_reset = 1'b1, b_en = 1'b0, b_ready = 1'b1;
    logic [1:0]  b_mode = 2'd0;
    logic [17:0] b_flit;
    logic        b_valid, b_done;
    logic [0:0]  b_vc;
    logic [15:0] b_pkts;

    // Instance C: NODE_ID=5, PACKET_LEN=1, INJECT_GAP=0, unlimited
    logic        c_reset = 1'b1, c_en = 1'b0, c_ready = 1'b0;
    logic [1:0]  c_mode = 2'd3;
    logic [17:0] c_flit;
    logic        c_valid, c_done;
    logic [0:0]  c_vc;
    logic [15:0] c_pkts;

    localparam logic [17:0] A_HEAD_D4 = {2'b01, 3'd4, 3'd3, 10'd0};
    localparam logic [17:0] A_HEAD_D0 = {2'b01, 3'd0, 3'd3, 10'd0};
    localparam logic [17:0] B_HEAD    = {2'b01, 3'd1, 3'd0, 10'd0};
    localparam logic [17:0] B_TAIL    = {2'b00, 16'd1};
    localparam logic [17:0] C_HEADER  = {2'b11, 3'd2, 3'd5, 10'd0};

    noc_traffic_gen #(
        .NUM_OF_NODES(8), .FLIT_DATA_WIDTH(16), .NUM_OF_VIRTUAL_CHANNELS(2), .NODE_ID(3),
        .PACKET_LEN(4), .INJECT_GAP(2), .NUM_PACKETS(3), .HOTSPOT_NODE(0), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(a_reset), .enable(a_en), .mode(a_mode), .flit_out(a_flit),
        .flit_valid(a_valid), .flit_ready(a_ready), .vc_sel(a_vc), .packets_sent(a_pkts), .done(a_done)
    );

    noc_traffic_gen #(
        .NUM_OF_NODES(8), .FLIT_DATA_WIDTH(16), .NUM_OF_VIRTUAL_CHANNELS(2), .NODE_ID(0),
        .PACKET_LEN(2), .INJECT_GAP(1), .NUM_PACKETS(0), .HOTSPOT_NODE(0), .LFSR_SEED(16'hACE1)
    ) dut_hot (
        .clk(clk), .reset(b_reset), .enable(b_en), .mode(b_mode), .flit_out(b_flit),
        .flit_valid(b_valid), .flit_ready(b_ready), .vc_sel(b_vc), .packets_sent(b_pkts), .done(b_done)
    );

    noc_traffic_gen #(
        .NUM_OF_NODES(8), .FLIT_DATA_WIDTH(16), .NUM_OF_VIRTUAL_CHANNELS(2), .NODE_ID(5),
        .PACKET_LEN(1), .INJECT_GAP(0), .NUM_PACKETS(0), .HOTSPOT_NODE(0), .LFSR_SEED(16'hACE1)
    ) dut_single (
        .clk(clk), .reset(c_reset), .enable(c_en), .mode(c_mode), .flit_out(c_flit),
        .flit_valid(c_valid), .flit_ready(c_ready), .vc_sel(c_vc), .packets_sent(c_pkts), .done(c_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] a_body(input int k);
        return (k == 3) ? {2'b00, 16'(k)} : {2'b10, 16'(k)};
    endfunction

    task automatic a_wait_valid(input int max_cycles, input string name);
        int n = 0;
        while (a_valid !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (a_valid !== 1'b1) begin failures++; $display("FAIL %s got=valid_low exp=valid_within_%0d", name, max_cycles); end
    endtask

    task automatic b_wait_valid(input int max_cycles, input string name);
        int n = 0;
        while (b_valid !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (b_valid !== 1'b1) begin failures++; $display("FAIL %s got=valid_low exp=valid_within_%0d", name, max_cycles); end
    endtask

    task automatic test_reset();
        a_reset = 1'b1; a_en = 1'b1; a_mode = 2'd2; a_ready = 1'b1;
        tick(); tick();
        checks++; if (a_valid !== 1'b0)    begin failures++; $display("FAIL reset_valid got=%b exp=0", a_valid); end
        checks++; if (a_flit !== 18'd0)    begin failures++; $display("FAIL reset_flit got=%h exp=0", a_flit); end
        checks++; if (a_vc !== 1'b0)       begin failures++; $display("FAIL reset_vc got=%0d exp=0", a_vc); end
        checks++; if (a_pkts !== 16'd0)    begin failures++; $display("FAIL reset_pkts got=%0d exp=0", a_pkts); end
        checks++; if (a_done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", a_done); end
    endtask

    task automatic test_first_packet();
        a_reset = 1'b0;
        tick();
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL gap_cycle1 got=%b exp=0", a_valid); end
        tick();
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL gap_cycle2 got=%b exp=0", a_valid); end
        tick();
        checks++; if (a_valid !== 1'b1)    begin failures++; $display("FAIL first_valid_timing got=%b exp=1", a_valid); end
        checks++; if (a_flit !== A_HEAD_D4) begin failures++; $display("FAIL head_neighbour got=%h exp=%h", a_flit, A_HEAD_D4); end
        checks++; if (a_vc !== 1'b0)       begin failures++; $display("FAIL first_vc got=%0d exp=0", a_vc); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if ({a_valid, a_flit} !== {1'b1, a_body(k)}) begin
                failures++; $display("FAIL pkt1_flit%0d got=%b/%h exp=1/%h", k, a_valid, a_flit, a_body(k));
            end
        end
        tick();
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL pkt1_end_valid got=%b exp=0", a_valid); end
        checks++; if (a_pkts !== 16'd1) begin failures++; $display("FAIL pkt1_count got=%0d exp=1", a_pkts); end
    endtask

    task automatic test_stall_random();
        a_mode = 2'd1;
        a_wait_valid(8, "pkt2_start");
        // LFSR 0xACE1 stepped once -> 0x5670, low bits 000
        checks++; if (a_flit !== A_HEAD_D0) begin failures++; $display("FAIL random_dest got=%h exp=%h", a_flit, A_HEAD_D0); end
        checks++; if (a_vc !== 1'b1)        begin failures++; $display("FAIL pkt2_vc got=%0d exp=1", a_vc); end
        tick();
        checks++; if (a_flit !== a_body(1)) begin failures++; $display("FAIL pkt2_body1 got=%h exp=%h", a_flit, a_body(1)); end
        a_ready = 1'b0;
        a_mode  = 2'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({a_valid, a_flit} !== {1'b1, a_body(1)}) begin
                failures++; $display("FAIL stall_hold%0d got=%b/%h exp=1/%h", i, a_valid, a_flit, a_body(1));
            end
        end
        a_ready = 1'b1;
        tick();
        checks++; if (a_flit !== a_body(2)) begin failures++; $display("FAIL post_stall_body2 got=%h exp=%h", a_flit, a_body(2)); end
        tick();
        checks++; if (a_flit !== a_body(3)) begin failures++; $display("FAIL post_stall_tail got=%h exp=%h", a_flit, a_body(3)); end
        tick();
        checks++; if (a_pkts !== 16'd2) begin failures++; $display("FAIL pkt2_count got=%0d exp=2", a_pkts); end
        checks++; if (a_done !== 1'b0)  begin failures++; $display("FAIL pkt2_done got=%b exp=0", a_done); end
    endtask

    task automatic test_done();
        int extra = 0;
        a_mode = 2'd2;
        a_wait_valid(8, "pkt3_start");
        checks++; if (a_flit !== A_HEAD_D4) begin failures++; $display("FAIL pkt3_head got=%h exp=%h", a_flit, A_HEAD_D4); end
        checks++; if (a_vc !== 1'b0)        begin failures++; $display("FAIL pkt3_vc got=%0d exp=0", a_vc); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (a_flit !== a_body(k)) begin failures++; $display("FAIL pkt3_flit%0d got=%h exp=%h", k, a_flit, a_body(k)); end
        end
        tick();
        checks++; if (a_pkts !== 16'd3) begin failures++; $display("FAIL final_count got=%0d exp=3", a_pkts); end
        checks++; if (a_done !== 1'b1)  begin failures++; $display("FAIL done_set got=%b exp=1", a_done); end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_valid !== 1'b0 || a_done !== 1'b1) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL done_absorbing got=%0d_bad_cycles exp=0", extra); end
    endtask

    task automatic test_reset_mid_packet();
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL done_cleared got=%b exp=0", a_done); end
        a_wait_valid(8, "restart_start");
        tick(); tick();
        checks++; if (a_flit !== a_body(2)) begin failures++; $display("FAIL abort_point got=%h exp=%h", a_flit, a_body(2)); end
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", a_valid); end
        a_wait_valid(8, "fresh_start");
        checks++; if (a_flit !== A_HEAD_D4) begin failures++; $display("FAIL fresh_head got=%h exp=%h", a_flit, A_HEAD_D4); end
        checks++; if (a_vc !== 1'b0)        begin failures++; $display("FAIL fresh_vc got=%0d exp=0", a_vc); end
        checks++; if (a_pkts !== 16'd0)     begin failures++; $display("FAIL fresh_count got=%0d exp=0", a_pkts); end
    endtask

    task automatic test_enable_gating();
        int extra = 0;
        a_en = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (a_flit !== a_body(k)) begin failures++; $display("FAIL gated_flit%0d got=%h exp=%h", k, a_flit, a_body(k)); end
        end
        tick();
        checks++; if (a_pkts !== 16'd1) begin failures++; $display("FAIL gated_complete got=%0d exp=1", a_pkts); end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (a_valid !== 1'b0) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL enable_low_start got=%0d_valid_cycles exp=0", extra); end
        a_en = 1'b1;
        tick(); tick();
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL gap_held_early got=%b exp=0", a_valid); end
        tick();
        checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL gap_held_start got=%b exp=1", a_valid); end
        checks++; if (a_vc !== 1'b1)    begin failures++; $display("FAIL gated_next_vc got=%0d exp=1", a_vc); end
    endtask

    task automatic test_hotspot();
        b_reset = 1'b0; b_en = 1'b1; b_mode = 2'd0; b_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            b_wait_valid(6, "hot_start");
            checks++; if (b_flit !== B_HEAD)   begin failures++; $display("FAIL hot_dest%0d got=%h exp=%h", p, b_flit, B_HEAD); end
            checks++; if (b_vc !== 1'(p % 2))  begin failures++; $display("FAIL hot_vc%0d got=%0d exp=%0d", p, b_vc, p % 2); end
            tick();
            checks++; if (b_flit !== B_TAIL)   begin failures++; $display("FAIL hot_tail%0d got=%h exp=%h", p, b_flit, B_TAIL); end
            tick();
        end
        checks++; if (b_pkts !== 16'd4) begin failures++; $display("FAIL hot_count got=%0d exp=4", b_pkts); end
        checks++; if (b_done !== 1'b0)  begin failures++; $display("FAIL hot_unlimited got=%b exp=0", b_done); end
    endtask

    task automatic test_single_flit();
        c_reset = 1'b0; c_en = 1'b1; c_mode = 2'd3; c_ready = 1'b0;
        tick();
        checks++; if (c_valid !== 1'b1)    begin failures++; $display("FAIL single_timing got=%b exp=1", c_valid); end
        checks++; if (c_flit !== C_HEADER) begin failures++; $display("FAIL single_header got=%h exp=%h", c_flit, C_HEADER); end
        tick();
        checks++; if (c_flit !== C_HEADER) begin failures++; $display("FAIL single_hold got=%h exp=%h", c_flit, C_HEADER); end
        c_ready = 1'b1;
        tick();
        checks++; if ({c_valid, c_pkts} !== {1'b0, 16'd1}) begin failures++; $display("FAIL single_accept got=%b/%0d exp=0/1", c_valid, c_pkts); end
        tick();
        checks++; if ({c_valid, c_vc} !== {1'b1, 1'b1}) begin failures++; $display("FAIL single_next got=%b/%0d exp=1/1", c_valid, c_vc); end
    endtask

    initial begin
        test_reset();
        test_first_packet();
        test_stall_random();
        test_done();
        test_reset_mid_packet();
        test_enable_gating();
        test_hotspot();
        test_single_flit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_traffic_gen.md
NOC_TRAFFIC_GEN -- requirements
Module: noc_traffic_gen

Interface
REQ-001 SHALL have parameter NUM_OF_NODES, default 8: node count of the spidergon ring.
REQ-002 SHALL have parameter FLIT_DATA_WIDTH, default 16: payload bits per flit, excluding the 2 type bits.
REQ-003 SHALL have parameter NUM_OF_VIRTUAL_CHANNELS, default 2: VC count per input port.
REQ-004 SHALL have parameter NODE_ID, default 0: source node of this generator.
REQ-005 SHALL have parameter PACKET_LEN, default 4: flits per packet, minimum 1.
REQ-006 SHALL have parameter INJECT_GAP, default 2: idle cycles between packets.
REQ-007 SHALL have parameter NUM_PACKETS, default 16: packets to send; 0 means unlimited.
REQ-008 SHALL have parameter HOTSPOT_NODE, default 0: destination used in hotspot mode.
REQ-009 SHALL have parameter LFSR_SEED, default 16'hACE1: non-zero LFSR seed.
REQ-010 SHALL have port clk, input, width 1: the single clock.
REQ-011 SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-012 SHALL have port enable, input, width 1: permits new packet starts.
REQ-013 SHALL have port mode, input, width 2: 0 hotspot, 1 uniform random, 2 neighbour, 3 bit-complement.
REQ-014 SHALL have port flit_out, output, width FLIT_DATA_WIDTH+2: {type[1:0], data}.
REQ-015 SHALL have port flit_valid, output, width 1: flit_out holds a valid flit.
REQ-016 SHALL have port flit_ready, input, width 1: the router accepts the flit.
REQ-017 SHALL have port vc_sel, output, width $clog2(NUM_OF_VIRTUAL_CHANNELS): VC for the current packet.
REQ-018 SHALL have port packets_sent, output, width 16: completed-packet count.
REQ-019 SHALL have port done, output, width 1: NUM_PACKETS reached.

Function
REQ-020 SHALL use flit types 01 head, 10 body, 00 tail, and 11 single-flit header when PACKET_LEN=1.
REQ-021 SHALL form head/header flit data as {dest, NODE_ID, zero pad}, with dest and NODE_ID each $clog2(NUM_OF_NODES) bits.
REQ-022 SHALL set body and tail flit data to the flit index within the packet (1..PACKET_LEN-1), zero-extended.
REQ-023 SHALL implement states GAP, HEAD, BODY and DONE.
REQ-024 SHALL, in GAP with enable high, increment a gap counter each cycle and go to HEAD when the count equals INJECT_GAP.
REQ-025 SHALL, in GAP with enable low, hold the gap counter.
REQ-026 SHALL compute dest on the GAP->HEAD transition and hold it for the whole packet.
REQ-027 SHALL keep flit_valid high in HEAD and BODY, and advance to the next flit only on a cycle where flit_valid && flit_ready.
REQ-028 SHALL hold flit_out stable while flit_valid && !flit_ready.
REQ-029 SHALL, on acceptance of the tail flit (or the header flit), increment packets_sent by 1, clear the gap counter and go to GAP.
REQ-030 SHALL go to DONE instead of GAP when the new packets_sent equals NUM_PACKETS (NUM_PACKETS≠0); DONE is absorbing until reset and sets done=1.
REQ-031 SHALL let a packet in progress complete when enable falls; enable gates packet starts only.
REQ-032 SHALL compute dest in mode 0 as HOTSPOT_NODE.
REQ-033 SHALL compute dest in mode 1 as lfsr[$clog2(NUM_OF_NODES)-1:0].
REQ-034 SHALL compute dest in mode 2 as (NODE_ID+1) mod NUM_OF_NODES.
REQ-035 SHALL compute dest in mode 3 as ~NODE_ID over $clog2(NUM_OF_NODES) bits.
REQ-036 SHALL, when a computed dest equals NODE_ID, replace it with (dest+1) mod NUM_OF_NODES.
REQ-037 SHALL sample mode on the GAP->HEAD transition only.
REQ-038 SHALL use a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, advanced once per packet start.
REQ-039 SHALL give the first packet vc_sel=0 and increment vc_sel modulo NUM_OF_VIRTUAL_CHANNELS per packet start.
REQ-040 SHALL let packets_sent wrap at 16 bits when NUM_PACKETS=0.
REQ-041 SHALL assert the first flit_valid exactly INJECT_GAP+1 cycles after the first cycle with reset low and enable high.

Reset
REQ-042 SHALL, on a reset-high clock edge, drive state=GAP, gap counter=0, flit_valid=0, flit_out=0, vc_sel=0, packets_sent=0, done=0 and lfsr=LFSR_SEED.
REQ-043 SHALL, on reset mid-packet, abort the packet and show flit_valid=0 from the next cycle.

Structure
REQ-044 SHALL place the flit type constants, the HEAD_TAIL=2 width and the FLIT_TOTAL_WIDTH rule in the shared package noc_pkg.
REQ-045 SHALL implement the LFSR as sub-module noc_lfsr, with ports clk, reset, advance and value.

Verification
REQ-046 SHALL cover: N=8, NODE_ID=3, mode 2, PACKET_LEN=4, flit_ready=1 -> head flit data dest=4 src=3, then body 1, body 2, tail 3, with flit_valid asserted for 4 consecutive cycles.
REQ-047 SHALL cover: NODE_ID=0, mode 0, HOTSPOT_NODE=0 -> dest=1 on every packet.
REQ-048 SHALL cover: flit_ready low for 5 cycles during the body flit -> flit_out stable for those cycles, no flit lost or duplicated.
REQ-049 SHALL cover: NUM_PACKETS=3, INJECT_GAP=2 -> packets_sent=3, done=1, no further flit_valid; vc_sel sequence 0,1,0.
REQ-050 SHALL cover: reset asserted on the 2nd body flit -> flit_valid=0 next cycle; after release, a fresh head flit with vc_sel=0 and packets_sent=0.
REQ-051 SHALL cover: PACKET_LEN=1, mode 3, NODE_ID=5 -> single flit with type 11 and dest=2.
